// File: rtl/apb_mem_responder.sv
// APB3 completer backed by a register-file memory with fixed wait states.
// Define APB_MEM_RESPONDER_PSTRB_EN to honour pstrb on writes.
module apb_mem_responder #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 8,
   parameter int DEPTH       = 32,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                pclk,
   input  logic                prstn,
   input  logic                psel,
   input  logic                penable,
   input  logic                pwrite,
   input  logic [ADDR_W-1:0]   paddr,
   input  logic [DATA_W-1:0]   pwdata,
   input  logic [DATA_W/8-1:0] pstrb,
   output logic                pready,
   output logic [DATA_W-1:0]   prdata,
   output logic                pslverr
);

   localparam int NB  = DATA_W / 8;
   localparam int OFF = $clog2(NB);
   localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [IW-1:0]       idx_q;
   logic                write_q;
   logic                err_q;
   logic [DATA_W-1:0]   rdata_q;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic [ADDR_W-1:0]   widx;
   logic                misal;
   logic                err_d;
   logic                setup;
   logic                commit;

   assign widx   = paddr >> OFF;
   assign misal  = (paddr & ADDR_W'(NB - 1)) != '0;
   assign err_d  = (32'(widx) >= 32'(DEPTH)) | misal;
   assign setup  = (state_q == IDLE) & psel & ~penable;
   assign pready = (state_q == ACCESS) & psel & penable
                 & (cnt_q == 4'd0);
   assign commit = pready & write_q & ~err_q;

   assign pslverr = pready & err_q;
   assign prdata  = (pready & ~write_q) ? rdata_q : '0;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (setup) begin
               state_d = ACCESS;
               cnt_d   = 4'(WAIT_CYCLES);
            end
         end
         ACCESS: begin
            // psel dropping mid-access aborts without a write
            if (!psel || pready) begin
               state_d = IDLE;
            end else if (penable) begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pclk or negedge prstn) begin
      if (!prstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (setup) begin
            idx_q   <= widx[IW-1:0];
            write_q <= pwrite;
            err_q   <= err_d;
            rdata_q <= (!pwrite && !err_d) ? mem_q[widx[IW-1:0]] : '0;
         end
      end
   end

`ifdef APB_MEM_RESPONDER_PSTRB_EN
   logic [NB-1:0] strb_q;

   always_ff @(posedge pclk or negedge prstn) begin
      if (!prstn) begin
         strb_q <= '0;
      end else if (setup) begin
         strb_q <= pstrb;
      end
   end

   always_ff @(posedge pclk or negedge prstn) begin
      if (!prstn) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (commit) begin
         for (int b = 0; b < NB; b++) begin
            if (strb_q[b]) mem_q[idx_q][b*8 +: 8] <= pwdata[b*8 +: 8];
         end
      end
   end
`else
   logic unused_strb;
   assign unused_strb = ^pstrb;

   always_ff @(posedge pclk or negedge prstn) begin
      if (!prstn) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (commit) begin
         mem_q[idx_q] <= pwdata;
      end
   end
`endif

endmodule

// File: doc/apb_mem_responder.md
Name: apb_mem_responder

Overview:
- Parametrised APB3 completer with a register-file memory, for block-level bus testing and as a simple peripheral scratchpad.
- Supports configurable data width, address width, depth and fixed wait states.
- Signals errors on out-of-range or misaligned accesses via pslverr.
- Sits behind the APB interconnect; one instance per psel.

Parameters:
- DATA_W, 32, data bus width in bits; one of 8, 16, 32.
- ADDR_W, 8, byte-address width of paddr.
- DEPTH, 32, number of DATA_W-bit words; DEPTH*(DATA_W/8) <= 2**ADDR_W.
- WAIT_CYCLES, 0, number of access-phase cycles with pready low before completion; 0..15.

Ports:
- pclk input 1 APB clock; all logic on rising edge.
- prstn input 1 async active-low reset.
- psel input 1 completer select.
- penable input 1 access-phase indicator.
- pwrite input 1 1=write, 0=read.
- paddr input ADDR_W byte address.
- pwdata input DATA_W write data.
- pstrb input DATA_W/8 byte write strobes; used only when the optional feature is enabled, ignored otherwise.
- pready output 1 transfer completion.
- prdata output DATA_W read data.
- pslverr output 1 transfer error, valid only with pready.

Behaviour:
- Reset (prstn=0, asynchronous):
  - state=IDLE, wait counter=0, read latch=0, all memory words=0.
  - pready=0, prdata=0, pslverr=0.
- Word index = paddr >> log2(DATA_W/8).
- Error condition, evaluated at setup:
  - word index >= DEPTH, or
  - paddr low bits not aligned to DATA_W/8.
- FSM states IDLE and ACCESS:
  - IDLE -> ACCESS when psel=1 and penable=0 (setup phase).
  - At that edge, latch paddr, pwrite, the error flag and pstrb, and load the counter with WAIT_CYCLES.
  - For a read with no error, also latch mem[index] into the read latch; on error, latch 0.
  - ACCESS: while the counter is nonzero and psel=penable=1, decrement by 1 per cycle.
  - ACCESS -> IDLE on the completing edge (pready=1).
  - ACCESS -> IDLE immediately if psel drops: abort, no write, no response.
- pready (combinational) = (state==ACCESS) & psel & penable & (counter==0).
  - WAIT_CYCLES=0: zero-wait transfer, exactly 2 cycles (setup + access).
  - WAIT_CYCLES=N: access phase lasts N+1 cycles.
- pslverr = pready & latched error; 0 at all other times.
- prdata = read latch when pready=1 and the latched pwrite=0; otherwise 0.
- Write commit:
  - Occurs on the edge where pready=1, latched pwrite=1 and no error.
  - mem[index] <= pwdata, sampled at the completing edge.
  - An erroring write never modifies memory.
- Back-to-back: a new setup phase may follow in the cycle right after completion; no idle cycle required.
- Read-after-write to the same address in consecutive transfers returns the new data, since the read latch samples at the later setup edge.
- Setup-phase address/control changes during ACCESS are ignored; latched values govern the transfer.
- Reset asserted mid-transfer: immediate return to IDLE, pready=0, memory cleared, no partial write.
- penable=1 seen in IDLE (protocol error): ignored, pready stays 0.

Optional Feature:
- Macro APB_MEM_RESPONDER_PSTRB_EN.
- Defined: writes update only bytes where the latched pstrb bit is 1; pstrb=0 performs no update but completes normally with pslverr=0.
- Not defined: pstrb is ignored and every successful write updates the full word.

Test Plan:
- Reset, then read addr 0x04 (DATA_W=32, WAIT_CYCLES=0) -> pready high in the 2nd cycle, prdata=0x00000000, pslverr=0.
- Write 0xDEADBEEF to 0x08, then read 0x08 back-to-back -> read completes in 2 cycles with prdata=0xDEADBEEF; pready=1 exactly once per transfer.
- WAIT_CYCLES=3: write 0x12345678 to 0x10 -> pready low for 3 access cycles, high on the 4th; the memory update is visible only after that edge.
- Read 0x80 (index 32 >= DEPTH=32) and write 0x02 (misaligned) -> pslverr=1 with pready; prdata=0; memory unchanged, confirmed by a subsequent read of 0x00.
- Drop psel after 1 access cycle of a WAIT_CYCLES=3 write to 0x0C, then assert prstn=0 mid-read -> no write occurs (0x0C reads 0); reset forces pready=0, prdata=0 and clears all memory.
- With APB_MEM_RESPONDER_PSTRB_EN: write 0xFFFFFFFF, then 0x00000000 with pstrb=4'b0101 -> readback 0xFF00FF00. Without the macro, the same sequence reads back 0x00000000.
